// File: rtl/moog_filter_axil_regs.sv
// AXI4-Lite register block holding the Moog ladder filter controls (CUTOFF, RESONANCE, GAIN, CTRL).
// Define MOOG_REGS_SHADOW_EN to stage writes in shadows and commit them to the core on sample_tick.
module moog_filter_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            sample_tick,
    output logic [31:0]                     cutoff_o,
    output logic [31:0]                     resonance_o,
    output logic [31:0]                     gain_o,
    output logic [31:0]                     ctrl_o,
    output logic                            update_o
);

    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic        update_q, update_d;
    logic [1:0]  awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic [1:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign update_o      = update_q;

    always_comb begin
        aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs      = S_AXI_WVALID && S_AXI_WREADY;
        ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
        // A half that was latched earlier takes priority over the live bus value.
        wr_idx    = aw_held_q ? awidx_q : S_AXI_AWADDR[3:2];
        wr_data   = w_held_q ? wdata_q : S_AXI_WDATA;
        wr_strb   = w_held_q ? wstrb_q : S_AXI_WSTRB;
        commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);

        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awidx_d   = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        // Reads sample the pre-write register value when a commit lands on the same edge.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q    <= '{default: '0};
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            update_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            update_q  <= update_d;
        end
    end

`ifdef MOOG_REGS_SHADOW_EN
    logic [31:0] live_q [4];
    logic [31:0] live_d [4];
    logic        pending_q, pending_d;

    // A commit on the tick edge is not yet in regs_q, so it stays pending for the next tick.
    always_comb begin
        live_d    = live_q;
        update_d  = 1'b0;
        if (sample_tick) begin
            live_d   = regs_q;
            update_d = pending_q;
        end
        pending_d = commit || (pending_q && !sample_tick);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            live_q    <= '{default: '0};
            pending_q <= 1'b0;
        end else begin
            live_q    <= live_d;
            pending_q <= pending_d;
        end
    end

    assign cutoff_o    = live_q[0];
    assign resonance_o = live_q[1];
    assign gain_o      = live_q[2];
    assign ctrl_o      = live_q[3];

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    always_comb update_d = commit;

    assign cutoff_o    = regs_q[0];
    assign resonance_o = regs_q[1];
    assign gain_o      = regs_q[2];
    assign ctrl_o      = regs_q[3];

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         sample_tick};
`endif

endmodule

// File: tb/tb_moog_filter_axil_regs.sv
// Self-checking bench for moog_filter_axil_regs: directed AXI-Lite scenarios plus randomized
// traffic against a transaction-level model of the register map and parameter outputs.
module tb_moog_filter_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready, sample_tick;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, update_o;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, cutoff_o, resonance_o, gain_o, ctrl_o;

    always #5 clk = ~clk;

    moog_filter_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .sample_tick(sample_tick),
        .cutoff_o(cutoff_o), .resonance_o(resonance_o), .gain_o(gain_o), .ctrl_o(ctrl_o),
        .update_o(update_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // Transaction-level model: register contents, core-facing values, outstanding responses.
    logic [31:0] m_reg [4];
    logic [31:0] m_out [4];
    logic        m_upd = 1'b0;
    logic        m_pend = 1'b0;
    int          m_bpend = 0;
    logic [1:0]  qa [$];
    logic [31:0] qd [$];
    logic [3:0]  qs [$];
    logic [31:0] rq [$];
    bit          mon_en = 1'b0;

    always @(negedge clk) begin : mon
        logic [1:0]  idx;
        logic [31:0] d;
        logic [3:0]  s;
        bit          commit;
        if (mon_en) begin
            chk("cutoff_o", cutoff_o, m_out[0]);
            chk("resonance_o", resonance_o, m_out[1]);
            chk("gain_o", gain_o, m_out[2]);
            chk("ctrl_o", ctrl_o, m_out[3]);
            chk1("update_o", update_o, m_upd);
            chk1("bvalid", bvalid, m_bpend != 0);
            if (bvalid) chk("bresp", {30'b0, bresp}, 32'h0);
            chk1("rvalid", rvalid, rq.size() != 0);
            if (rvalid && rq.size() != 0) begin
                chk("rdata", rdata, rq[0]);
                chk("rresp", {30'b0, rresp}, 32'h0);
            end

            // Advance the model to the state after the coming rising edge.
            commit = 1'b0;
            if (awvalid && awready) qa.push_back(awaddr[3:2]);
            if (wvalid && wready) begin
                qd.push_back(wdata);
                qs.push_back(wstrb);
            end
            if (rvalid && rready && rq.size() != 0) void'(rq.pop_front());
            if (arvalid && arready) rq.push_back(m_reg[araddr[3:2]]);
            if (bvalid && bready && m_bpend > 0) m_bpend--;
`ifdef MOOG_REGS_SHADOW_EN
            m_upd = sample_tick && m_pend;
            if (sample_tick) m_out = m_reg;
`endif
            if (qa.size() != 0 && qd.size() != 0) begin
                idx = qa.pop_front();
                d   = qd.pop_front();
                s   = qs.pop_front();
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
                commit = 1'b1;
                m_bpend++;
            end
`ifdef MOOG_REGS_SHADOW_EN
            m_pend = commit || (m_pend && !sample_tick);
`else
            m_upd = commit;
            if (commit) m_out = m_reg;
`endif
        end
    end

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ad = 1'b0;
        bit wd = 1'b0;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(ad && wd)) begin
            @(negedge clk);
            if (awvalid && awready) ad = 1'b1;
            if (wvalid && wready) wd = 1'b1;
            @(posedge clk); #1;
            if (ad) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
            n++;
            if (n > 50) begin
                timeout("write_handshake");
                awvalid = 1'b0; wvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (bvalid && bready) break;
            n++;
            if (n > 50) begin
                timeout("write_response");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        d = '0;
        araddr = a; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) timeout("read_address");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 50);
        if (!rvalid) timeout("read_data");
        d = rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        bit aw_done, w_done, ar_done;
        awvalid = 0; wvalid = 0; arvalid = 0; sample_tick = 0;
        bready = 1; rready = 1;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
        for (int i = 0; i < 4; i++) begin
            m_reg[i] = '0;
            m_out[i] = '0;
        end

        #202;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk1("awready_rst", awready, 1'b1);
        chk1("wready_rst", wready, 1'b1);
        chk1("arready_rst", arready, 1'b1);
        chk1("bvalid_rst", bvalid, 1'b0);
        chk1("rvalid_rst", rvalid, 1'b0);
        chk1("update_rst", update_o, 1'b0);
        chk("cutoff_rst", cutoff_o, 32'h0);
        chk("ctrl_rst", ctrl_o, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            chk("rd_rst", rd, 32'h0);
        end

        // Sequential writes then readback
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF);
            wait_b();
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            chk("rd_seq", rd, 32'(i + 1));
        end

        // W leads AW by three cycles
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        chk1("wready_first", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk1("wready_held", wready, 1'b0);
            @(posedge clk); #1;
        end
        awaddr = 4'h8; awvalid = 1'b1;
        @(negedge clk);
        chk1("awready_late", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk1("bvalid_after_aw", bvalid, 1'b1);
        @(posedge clk); #1;
        axi_read(4'h8, rd);
        chk("rd_gain_order", rd, 32'hDEADBEEF);

        // Byte strobes
        axi_write(4'h0, 32'h11111111, 4'hF);
        wait_b();
        axi_write(4'h0, 32'hAABBCCDD, 4'b0010);
        wait_b();
        axi_read(4'h0, rd);
        chk("rd_strobe", rd, 32'h1111CC11);

        // Write response backpressure with a second write offered
        bready = 1'b0;
        axi_write(4'h4, 32'h77, 4'hF);
        awaddr = 4'hC; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk1("awready_bp", awready, 1'b0);
            chk1("wready_bp", wready, 1'b0);
            chk1("bvalid_bp", bvalid, 1'b1);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        axi_write(4'hC, 32'h99, 4'hF);
        wait_b();
        axi_read(4'h4, rd);
        chk("rd_res_bp", rd, 32'h77);
        axi_read(4'hC, rd);
        chk("rd_ctrl_bp", rd, 32'h99);

        // Read data held under RREADY backpressure
        rready = 1'b0;
        araddr = 4'h0; arvalid = 1'b1;
        @(negedge clk);
        chk1("arready_rbp", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk1("rvalid_rbp", rvalid, 1'b1);
            chk("rdata_rbp", rdata, 32'h1111CC11);
            chk1("arready_rbp_low", arready, 1'b0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;

        // Parameter commit to the core
        axi_write(4'h0, 32'h55, 4'hF);
`ifdef MOOG_REGS_SHADOW_EN
        @(negedge clk);
        chk("cutoff_no_tick", cutoff_o, 32'h0);
        chk1("update_no_tick", update_o, 1'b0);
        @(posedge clk); #1;
        axi_read(4'h0, rd);
        chk("rd_shadow", rd, 32'h55);
        chk("cutoff_still_0", cutoff_o, 32'h0);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(negedge clk);
        chk("cutoff_tick", cutoff_o, 32'h55);
        chk1("update_tick", update_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("update_once", update_o, 1'b0);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(negedge clk);
        chk1("update_idle_tick", update_o, 1'b0);
        chk("cutoff_idle_tick", cutoff_o, 32'h55);
        @(posedge clk); #1;
`else
        @(negedge clk);
        chk("cutoff_commit", cutoff_o, 32'h55);
        chk1("update_commit", update_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("update_once", update_o, 1'b0);
        @(posedge clk); #1;
`endif

        // Randomized traffic with random backpressure and sample ticks
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            aw_done = awvalid && awready;
            w_done  = wvalid && wready;
            ar_done = arvalid && arready;
            @(posedge clk); #1;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            if (ar_done) arvalid = 1'b0;
            if (c < 2900) begin
                if (!awvalid && $urandom_range(0, 2) == 0) begin
                    awvalid = 1'b1; awaddr = 4'($urandom); awprot = 3'($urandom);
                end
                if (!wvalid && $urandom_range(0, 2) == 0) begin
                    wvalid = 1'b1; wdata = $urandom; wstrb = 4'($urandom);
                end
                if (!arvalid && $urandom_range(0, 2) == 0) begin
                    arvalid = 1'b1; araddr = 4'($urandom); arprot = 3'($urandom);
                end
                bready = $urandom_range(0, 3) != 0;
                rready = $urandom_range(0, 3) != 0;
                sample_tick = $urandom_range(0, 7) == 0;
            end else begin
                bready = 1'b1;
                rready = 1'b1;
                sample_tick = 1'b0;
            end
        end

        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            chk("rd_final", rd, m_reg[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
